// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : result_uart_tx
//  Description : Serial result reporter. A small byte FIFO feeds an 8N1 UART
//                serializer that drives a single idle-high output line.
//                Frames queued back-to-back leave with no idle gap between
//                the stop bit of one frame and the start bit of the next.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [7:0]                       in_data,
    output logic                             in_ready,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_LVL_W-1:0] c_FULL     = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    // Serializer state
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_tx_nxt;
    logic               w_pop;
    logic               w_push;
    logic               w_not_empty;
    logic               w_bit_done;
    logic [7:0]         w_head;

    // A full FIFO refuses input even on a cycle where the serializer pops,
    // so in_ready depends on registered state only.
    assign in_ready    = (r_level != c_FULL);
    assign w_push      = in_valid & in_ready;
    assign w_not_empty = (r_level != '0);
    assign w_bit_done  = (r_cnt == c_CNT_LAST);
    assign w_head      = r_mem[r_rd_ptr];

    assign tx          = r_tx;
    assign busy        = (r_state != c_IDLE) | w_not_empty;
    assign fifo_level  = r_level;

    // Store accepted bytes; pointer reset makes stale contents unreachable
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - c_LVL_W'(1);
            end
        end
    end

    // Serializer state register; tx is registered so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles, LSB first
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = c_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = c_STOP;
                    end else begin
                        // r_shift[1] is the bit that becomes LSB after the shift
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (w_not_empty) begin
                        // Chain straight into the next start bit
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_idx_nxt   = '0;
                        w_state_nxt = c_START;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_uart_tx
//  Description : Self-checking bench for result_uart_tx with a line-level
//                UART receiver model and frame waveform expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int FRAME = 10 * CPB;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data  = 8'h00;
    logic             in_ready;
    logic             tx;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    int tests = 0;
    int fails = 0;

    // Receiver output: {stop_ok_and_start_ok, byte}
    logic [8:0] rx_q[$];
    bit         rx_en = 1'b1;
    logic [7:0] rx_b;
    logic       rx_ok;

    result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line level at cycle pos (0..FRAME-1) of an 8N1 frame
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[pos / CPB];
    endfunction

    // Line-level UART receiver sampling near mid-bit on the falling clock edge
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && !rst && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                rx_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                rx_ok = rx_ok & (tx === 1'b1);
                rx_q.push_back({rx_ok, rx_b});
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hC3;
        tick; tick;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL t1_tx actual=%b required=1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy actual=%b required=0", busy); end
        tests++; if (fifo_level !== '0) begin fails++; $display("FAIL t1_level actual=%0d required=0", fifo_level); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t1_ready actual=%b required=1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) tick;
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1 || fifo_level !== '0) begin
            fails++; $display("FAIL t1_nothing_queued busy=%b tx=%b level=%0d required busy=0 tx=1 level=0", busy, tx, fifo_level);
        end
    endtask

    task automatic test_single_byte;
        logic [7:0] b;
        int werr, first;
        b = 8'hA5; werr = 0; first = -1;
        rx_q.delete();
        in_valid = 1'b1; in_data = b;
        tick;                                   // edge N: push
        in_valid = 1'b0; in_data = 8'($urandom);
        tests++;
        if (fifo_level !== LVL_W'(1) || tx !== 1'b1) begin
            fails++; $display("FAIL t2_after_push level=%0d tx=%b required level=1 tx=1", fifo_level, tx);
        end
        for (int k = 0; k < FRAME; k++) begin
            tick;                               // edge N+1+k
            if (tx !== frame_bit(b, k)) begin werr++; if (first < 0) first = k; end
            if (k == FRAME - 1) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL t2_busy_at_N+40 actual=%b required=1", busy); end
            end
        end
        tests++; if (werr != 0) begin fails++; $display("FAIL t2_wave mismatches=%0d first_offset=%0d required=0", werr, first); end
        tick;                                   // edge N+41
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL t2_end tx=%b busy=%b required tx=1 busy=0", tx, busy);
        end
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, b}) begin
            fails++; $display("FAIL t2_rx count=%0d first=%h required count=1 byte=1a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    // Burst of 0x01..0x06 with in_valid held; includes the full-FIFO pop boundary
    task automatic test_back_to_back;
        int nxt, acc6, werr, first, kk;
        logic rdy;
        logic [7:0] exp_b;
        nxt = 1; acc6 = -1; werr = 0; first = -1;
        rx_q.delete();
        for (int e = 0; e <= 241; e++) begin
            in_valid = (nxt <= 6);
            in_data  = 8'(nxt);
            rdy      = in_ready;
            if (e == 41) begin
                tests++;
                if (in_ready !== 1'b0 || fifo_level !== LVL_W'(4)) begin
                    fails++; $display("FAIL t6_before_pop ready=%b level=%0d required ready=0 level=4", in_ready, fifo_level);
                end
            end
            tick;
            if (in_valid && rdy) begin
                if (nxt == 6) acc6 = e;
                nxt++;
            end
            if (e == 4) begin
                tests++;
                if (nxt != 6 || fifo_level !== LVL_W'(4) || in_ready !== 1'b0) begin
                    fails++; $display("FAIL t3_fill accepted=%0d level=%0d ready=%b required accepted=5 level=4 ready=0", nxt - 1, fifo_level, in_ready);
                end
            end
            if (e == 41) begin
                tests++;
                if (fifo_level !== LVL_W'(3) || tx !== 1'b0) begin
                    fails++; $display("FAIL t6_pop_no_push level=%0d tx=%b required level=3 tx=0", fifo_level, tx);
                end
            end
            if (e == 42) begin
                tests++;
                if (fifo_level !== LVL_W'(4)) begin
                    fails++; $display("FAIL t6_push_next level=%0d required=4", fifo_level);
                end
            end
            if (e >= 1 && e <= 6 * FRAME) begin
                kk = e - 1;
                exp_b = 8'(kk / FRAME + 1);
                if (tx !== frame_bit(exp_b, kk % FRAME)) begin werr++; if (first < 0) first = kk; end
            end
        end
        tests++; if (acc6 != 42) begin fails++; $display("FAIL t3_accept6_edge actual=%0d required=42", acc6); end
        tests++; if (werr != 0) begin fails++; $display("FAIL t3_wave mismatches=%0d first_offset=%0d required=0", werr, first); end
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++; $display("FAIL t3_end busy=%b tx=%b required busy=0 tx=1", busy, tx);
        end
        werr = 0;
        if (rx_q.size() != 6) werr = 99;
        else for (int i = 0; i < 6; i++) if (rx_q[i] !== {1'b1, 8'(i + 1)}) werr++;
        tests++; if (werr != 0) begin fails++; $display("FAIL t3_rx count=%0d errors=%0d required count=6 errors=0", rx_q.size(), werr); end
    endtask

    // Random producer against back-pressure; receiver must see the exact sequence
    task automatic test_stall_integrity;
        logic [7:0] sent[$];
        int idx, cyc, err, first;
        logic rdy;
        rx_q.delete();
        for (int i = 0; i < 64; i++) sent.push_back(8'($urandom));
        idx = 0; cyc = 0; err = 0; first = -1;
        in_valid = 1'b0;
        while (idx < 64 && cyc < 8000) begin
            if (!in_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    in_valid = 1'b1; in_data = sent[idx];
                end else begin
                    in_data = 8'($urandom);
                end
            end
            rdy = in_ready;
            tick; cyc++;
            if (in_valid && rdy) begin
                idx++; in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++; if (idx != 64) begin fails++; $display("FAIL t4_push_timeout pushed=%0d required=64", idx); end
        for (int c = 0; c < 4000 && !(rx_q.size() >= 64 && busy === 1'b0); c++) tick;
        repeat (4) tick;
        tests++; if (rx_q.size() != 64) begin fails++; $display("FAIL t4_rx_count actual=%0d required=64", rx_q.size()); end
        for (int i = 0; i < 64 && i < rx_q.size(); i++) begin
            if (rx_q[i] !== {1'b1, sent[i]}) begin err++; if (first < 0) first = i; end
        end
        tests++; if (err != 0) begin fails++; $display("FAIL t4_rx_data errors=%0d first_index=%0d required=0", err, first); end
    endtask

    // Reset during data bit 3 of 0x3C with two bytes still queued
    task automatic test_reset_mid_frame;
        int low;
        rx_en = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        tick;                                   // e0 push 0x3C
        in_data = 8'($urandom);
        tick;                                   // e1 pop 0x3C, push
        in_data = 8'($urandom);
        tick;                                   // e2 push
        in_valid = 1'b0;
        repeat (15) tick;                       // post e17: inside data bit 3
        tests++;
        if (fifo_level !== LVL_W'(2) || busy !== 1'b1 || tx !== frame_bit(8'h3C, 16)) begin
            fails++; $display("FAIL t5_pre level=%0d busy=%b tx=%b required level=2 busy=1 tx=%b", fifo_level, busy, tx, frame_bit(8'h3C, 16));
        end
        rst = 1'b1;
        tick;
        tests++;
        if (tx !== 1'b1 || fifo_level !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL t5_reset tx=%b level=%0d busy=%b ready=%b required tx=1 level=0 busy=0 ready=1", tx, fifo_level, busy, in_ready);
        end
        rst = 1'b0;
        low = 0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (tx !== 1'b1 || busy !== 1'b0) low++;
        end
        tests++; if (low != 0) begin fails++; $display("FAIL t5_quiet active_cycles=%0d required=0", low); end
        rx_q.delete(); rx_en = 1'b1;
        in_valid = 1'b1; in_data = 8'h5A;
        tick;
        in_valid = 1'b0;
        repeat (FRAME + 4) tick;
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h5A}) begin
            fails++; $display("FAIL t5_new_push count=%0d first=%h required count=1 byte=15a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_stall_integrity();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
